// File: rtl/noc_input_port_if.sv
// Flit handshake bundle between an upstream link, the input port and the crossbar.
// slave is the input-port side; master is the link/crossbar side that drives it.
interface noc_input_port_if #(
    parameter int FLIT_W = 64,
    parameter int OCC_W  = 3
);
    logic [FLIT_W-1:0] in_flit;
    logic              in_valid;
    logic              in_ready;
    logic [FLIT_W-1:0] out_flit;
    logic              out_valid;
    logic [4:0]        out_req;
    logic              out_grant;
    logic [OCC_W-1:0]  occupancy;
    logic              err_drop;

    modport slave (
        input  in_flit, in_valid, out_grant,
        output in_ready, out_flit, out_valid, out_req, occupancy, err_drop
    );

    modport master (
        output in_flit, in_valid, out_grant,
        input  in_ready, out_flit, out_valid, out_req, occupancy, err_drop
    );
endinterface

// File: rtl/noc_input_port.sv
// Router input stage: flit FIFO, XY route decode of the head flit, wormhole
// route hold, and dropping of stray flits / out-of-mesh packets.
module noc_input_port #(
    parameter int FLIT_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int ROWS       = 2,
    parameter int COLS       = 2,
    parameter int R          = 0,
    parameter int C          = 0,
    parameter int COORD_W    = 4
) (
    input logic              clk,
    input logic              rst,
    noc_input_port_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [COORD_W-1:0] R_L    = COORD_W'(R);
    localparam logic [COORD_W-1:0] C_L    = COORD_W'(C);
    localparam logic [COORD_W:0]   ROWS_L = (COORD_W+1)'(ROWS);
    localparam logic [COORD_W:0]   COLS_L = (COORD_W+1)'(COLS);

    // one-hot output ports, bit0=N .. bit4=L
    localparam logic [4:0] P_N = 5'b00001;
    localparam logic [4:0] P_E = 5'b00010;
    localparam logic [4:0] P_S = 5'b00100;
    localparam logic [4:0] P_W = 5'b01000;
    localparam logic [4:0] P_L = 5'b10000;

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    logic [FLIT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [OCC_W-1:0]  count;
    logic              push, pop, empty;
    state_t            state_q, state_d;
    logic [4:0]        route_q, route_d, route_xy;
    logic              out_valid, err_drop;

    logic [FLIT_W-1:0]  head;
    logic [1:0]         head_type;
    logic               is_start, is_end, in_range;
    logic [COORD_W-1:0] dst_row, dst_col;

    assign empty     = (count == '0);
    assign head      = mem[rd_ptr];
    assign head_type = head[FLIT_W-1 -: 2];
    assign is_start  = head_type[0];   // head (01) or single (11)
    assign is_end    = head_type[1];   // tail (10) or single (11)
    assign dst_row   = head[FLIT_W-3 -: COORD_W];
    assign dst_col   = head[FLIT_W-3-COORD_W -: COORD_W];
    assign in_range  = ({1'b0, dst_row} < ROWS_L) && ({1'b0, dst_col} < COLS_L);

    always_comb begin
        route_xy = P_L;
        if (dst_col > C_L)      route_xy = P_E;
        else if (dst_col < C_L) route_xy = P_W;
        else if (dst_row > R_L) route_xy = P_S;
        else if (dst_row < R_L) route_xy = P_N;
    end

    assign bus.in_ready = (count < OCC_W'(FIFO_DEPTH));
    assign push         = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d   = state_q;
        route_d   = route_q;
        pop       = 1'b0;
        out_valid = 1'b0;
        err_drop  = 1'b0;
        case (state_q)
            IDLE: if (!empty) begin
                if (is_start) begin
                    if (in_range) begin
                        route_d = route_xy;
                        state_d = ROUTE;
                    end else begin
                        err_drop = 1'b1;
                        state_d  = DROP;
                    end
                end else begin
                    pop      = 1'b1;
                    err_drop = 1'b1;
                end
            end
            ROUTE: begin
                out_valid = !empty;
                pop       = out_valid && bus.out_grant;
                if (pop && is_end) state_d = IDLE;
            end
            DROP: begin
                pop = !empty;
                if (pop && is_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            route_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + OCC_W'(push) - OCC_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_flit;
    end

    // stale storage is masked so an empty FIFO always shows a zero flit
    assign bus.out_flit  = empty ? '0 : head;
    assign bus.out_valid = out_valid;
    assign bus.out_req   = out_valid ? route_q : 5'b0;
    assign bus.occupancy = count;
    assign bus.err_drop  = err_drop;
endmodule
